// File: rtl/spart_driver.sv
// SPART echo driver: programs the baud divisor from br_cfg, then echoes every received byte.
// Latency: 4 cycles IDLE->IDLE per echo with tbr=1; all outputs registered. Stalls in WAIT_TBR while tbr=0.
module spart_driver (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  br_cfg,
    input  logic        rda,
    input  logic        tbr,
    input  logic [7:0]  db_in,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    output logic [7:0]  db_out,
    output logic        db_oe,
    output logic        cfg_done,
    output logic [15:0] echo_cnt
);
    typedef enum logic [2:0] {INIT, CFG_LO, CFG_HI, IDLE, READ, WAIT_TBR, WRITE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  br_meta, br_sync;
    logic [1:0]  cfg_reg, cfg_nxt;
    logic [7:0]  rx_byte;
    logic [15:0] div_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_meta <= 2'b00;
            br_sync <= 2'b00;
        end else begin
            br_meta <= br_cfg;
            br_sync <= br_meta;
        end
    end

    // A pending baud change wins over rda so the link never runs on a stale divisor.
    always_comb begin
        state_nxt = state;
        cfg_nxt   = cfg_reg;
        case (state)
            INIT: begin
                state_nxt = CFG_LO;
                cfg_nxt   = br_sync;
            end
            CFG_LO:   state_nxt = CFG_HI;
            CFG_HI:   state_nxt = IDLE;
            IDLE: begin
                if (br_sync != cfg_reg) begin
                    state_nxt = CFG_LO;
                    cfg_nxt   = br_sync;
                end else if (rda) begin
                    state_nxt = READ;
                end
            end
            READ:     state_nxt = WAIT_TBR;
            WAIT_TBR: if (tbr) state_nxt = WRITE;
            WRITE:    state_nxt = IDLE;
            default:  state_nxt = INIT;
        endcase
    end

    always_comb begin
        case (cfg_nxt)
            2'b00:   div_nxt = 16'h028A;
            2'b01:   div_nxt = 16'h0145;
            2'b10:   div_nxt = 16'h00A2;
            default: div_nxt = 16'h0050;
        endcase
    end

    // Outputs are loaded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            cfg_reg  <= 2'b00;
            rx_byte  <= 8'h00;
            echo_cnt <= 16'h0000;
            cfg_done <= 1'b0;
            iocs     <= 1'b0;
            iorw     <= 1'b0;
            ioaddr   <= 2'b00;
            db_out   <= 8'h00;
            db_oe    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cfg_reg <= cfg_nxt;
            if (state == READ)
                rx_byte <= db_in;
            if (state_nxt == CFG_LO)
                cfg_done <= 1'b0;
            else if (state == CFG_HI)
                cfg_done <= 1'b1;
            if (state == WRITE)
                echo_cnt <= echo_cnt + 16'd1;

            iocs   <= 1'b0;
            iorw   <= 1'b0;
            ioaddr <= 2'b00;
            db_out <= 8'h00;
            db_oe  <= 1'b0;
            case (state_nxt)
                CFG_LO: begin
                    iocs   <= 1'b1;
                    ioaddr <= 2'b10;
                    db_out <= div_nxt[7:0];
                    db_oe  <= 1'b1;
                end
                CFG_HI: begin
                    iocs   <= 1'b1;
                    ioaddr <= 2'b11;
                    db_out <= div_nxt[15:8];
                    db_oe  <= 1'b1;
                end
                READ: begin
                    iocs <= 1'b1;
                    iorw <= 1'b1;
                end
                WRITE: begin
                    iocs   <= 1'b1;
                    db_out <= rx_byte;
                    db_oe  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spart_driver.sv
// Randomized bench for spart_driver: stimulus pushes expected bus accesses into a queue,
// a negedge monitor pops and compares each access the DUT presents.
module tb_spart_driver;
    logic        clk;
    logic        rst_n;
    logic [1:0]  br_cfg;
    logic        rda;
    logic        tbr;
    logic [7:0]  db_in;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    logic [7:0]  db_out;
    logic        db_oe;
    logic        cfg_done;
    logic [15:0] echo_cnt;

    spart_driver dut (
        .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg), .rda(rda), .tbr(tbr), .db_in(db_in),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .db_out(db_out), .db_oe(db_oe),
        .cfg_done(cfg_done), .echo_cnt(echo_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [11:0] exp_q[$];
    logic [15:0] div_tab[4] = '{16'd650, 16'd325, 16'd162, 16'd80};
    logic [1:0]  cur_cfg;
    logic [15:0] model_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [11:0] acc(input logic rw, input logic [1:0] addr,
                                        input logic [7:0] data, input logic oe);
        return {rw, addr, data, oe};
    endfunction

    task automatic push_cfg(input logic [1:0] sel);
        logic [15:0] d;
        d = div_tab[sel];
        exp_q.push_back(acc(1'b0, 2'b10, d[7:0], 1'b1));
        exp_q.push_back(acc(1'b0, 2'b11, d[15:8], 1'b1));
    endtask

    // Monitor: every access is one expected entry, in order.
    logic       prev_iocs;
    logic       prev_rw;
    logic [1:0] prev_addr;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_iocs <= 1'b0;
        end else begin
            if (iocs) begin
                check("oe_during_read", {31'd0, db_oe & iorw}, 32'd0);
                if (prev_iocs)
                    check("back_to_back", {26'd0, prev_rw, prev_addr, iorw, ioaddr}, 32'b0_10_0_11);
                if (!iorw && ioaddr[1])
                    check("cfg_done_low_in_cfg", {31'd0, cfg_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_access: got %0h expected none",
                             {iorw, ioaddr, db_out, db_oe});
                end else begin
                    check("bus_access", {20'd0, iorw, ioaddr, db_out, db_oe}, {20'd0, exp_q.pop_front()});
                end
            end
            prev_iocs <= iocs;
            prev_rw   <= iorw;
            prev_addr <= ioaddr;
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_zero();
        check("rst_iocs", {31'd0, iocs}, 0);
        check("rst_iorw", {31'd0, iorw}, 0);
        check("rst_ioaddr", {30'd0, ioaddr}, 0);
        check("rst_db_out", {24'd0, db_out}, 0);
        check("rst_db_oe", {31'd0, db_oe}, 0);
        check("rst_cfg_done", {31'd0, cfg_done}, 0);
        check("rst_echo_cnt", {16'd0, echo_cnt}, 0);
    endtask

    // After release the synchroniser still holds 00, so the 00 divisor goes out first;
    // a different switch setting is then picked up from IDLE.
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        push_cfg(2'b00);
        if (br_cfg != 2'b00) push_cfg(br_cfg);
        cur_cfg   = br_cfg;
        model_cnt = 16'h0000;
        wait_drain();
        check("cfg_done_after_cfg", {31'd0, cfg_done}, 1);
    endtask

    task automatic change_br_idle(input logic [1:0] s);
        @(negedge clk);
        br_cfg = s;
        if (s != cur_cfg) push_cfg(s);
        cur_cfg = s;
        wait_drain();
        check("cfg_done_after_change", {31'd0, cfg_done}, 1);
    endtask

    // new_br < 0: no baud change; together: change lands in IDLE with rda; else during WAIT_TBR.
    task automatic echo(input logic [7:0] b, input int h_in, input int new_br, input bit together);
        int  h, cnt;
        bit  got, quiet;
        h = h_in;
        if (new_br >= 0 && !together && h < 1) h = 1;
        @(negedge clk);
        if (new_br >= 0 && together) begin
            br_cfg = new_br[1:0];
            if (new_br[1:0] != cur_cfg) push_cfg(new_br[1:0]);
            cur_cfg = new_br[1:0];
            repeat (2) @(negedge clk);
        end
        exp_q.push_back(acc(1'b1, 2'b00, 8'h00, 1'b0));
        exp_q.push_back(acc(1'b0, 2'b00, b, 1'b1));
        model_cnt = model_cnt + 16'd1;
        db_in = b;
        tbr   = (h == 0);
        rda   = 1'b1;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (iocs && iorw) got = 1;
        end
        rda = 1'b0;
        check("read_seen", {31'd0, got}, 1);
        if (!got) begin
            tbr = 1'b1;
            return;
        end
        cnt = 0;
        quiet = 1;
        repeat (h) begin
            @(negedge clk);
            cnt++;
            if (iocs) quiet = 0;
            if (cnt == 1 && new_br >= 0 && !together) begin
                br_cfg = new_br[1:0];
                if (new_br[1:0] != cur_cfg) push_cfg(new_br[1:0]);
                cur_cfg = new_br[1:0];
            end
        end
        if (h > 0) check("quiet_in_wait_tbr", {31'd0, quiet}, 1);
        tbr = 1'b1;
        got = 0;
        while (!got && cnt < 80) begin
            @(negedge clk);
            cnt++;
            if (iocs && !iorw && ioaddr == 2'b00) got = 1;
        end
        check("write_seen", {31'd0, got}, 1);
        check("write_latency", cnt, (h < 1 ? 1 : h) + 1);
        wait_drain();
        check("echo_cnt", {16'd0, echo_cnt}, {16'd0, model_cnt});
        if (new_br >= 0) check("cfg_done_after_echo_cfg", {31'd0, cfg_done}, 1);
    endtask

    initial begin
        int mode;
        bit got;
        rst_n  = 1'b0;
        br_cfg = 2'b01;
        rda    = 1'b0;
        tbr    = 1'b1;
        db_in  = 8'h00;
        cur_cfg   = 2'b00;
        model_cnt = 16'h0000;
        repeat (3) @(negedge clk);
        check_outputs_zero();
        release_reset();

        echo(8'h5A, 0, -1, 1'b0);
        echo(8'hC3, 20, -1, 1'b0);
        echo(8'h71, 6, 3, 1'b0);
        echo(8'h9E, 0, 2, 1'b1);

        for (int n = 0; n < 30; n++) begin
            mode = $urandom_range(0, 9);
            if (mode < 2)
                change_br_idle(2'($urandom_range(0, 3)));
            if (mode >= 2 && mode < 4)
                echo(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
            else if (mode == 4)
                echo(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 3), 1'b1);
            else
                echo(8'($urandom), $urandom_range(0, 4), -1, 1'b0);
        end

        @(negedge clk);
        force dut.echo_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.echo_cnt;
        model_cnt = 16'hFFFF;
        echo(8'hA5, 1, -1, 1'b0);
        check("echo_cnt_wrap", {16'd0, echo_cnt}, 0);

        // Reset in the middle of CFG_HI: outputs drop immediately, full sequence replays.
        @(negedge clk);
        br_cfg = (cur_cfg == 2'b10) ? 2'b00 : 2'b10;
        push_cfg(br_cfg);
        cur_cfg = br_cfg;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (iocs && !iorw && ioaddr == 2'b11) got = 1;
        end
        check("cfg_hi_seen", {31'd0, got}, 1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero();
        repeat (2) @(negedge clk);
        release_reset();
        echo(8'h3C, 2, -1, 1'b0);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
